// File: rtl/mmio_uart_bridge_if.sv
// CPU memory-stage IO bus and UART byte handshakes for mmio_uart_bridge.
// master: CPU/UART side driving requests and received bytes.
// slave : the bridge.
interface mmio_uart_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [31:0]           io_addr;
  logic [DATA_WIDTH-1:0] io_wdata;
  logic                  io_we;
  logic                  io_re;
  logic                  inst_retire;
  logic [DATA_WIDTH-1:0] io_rdata;
  logic [7:0]            uart_tx_data;
  logic                  uart_tx_valid;
  logic                  uart_tx_ready;
  logic [7:0]            uart_rx_data;
  logic                  uart_rx_valid;
  logic                  uart_rx_ready;

  modport master (
    output io_addr, io_wdata, io_we, io_re, inst_retire,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  io_rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  io_addr, io_wdata, io_we, io_re, inst_retire,
    input  uart_tx_ready, uart_rx_data, uart_rx_valid,
    output io_rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/mmio_uart_bridge.sv
// Memory-mapped IO controller between the CPU memory stage and the UART.
// Owns a one-entry TX holding register, an RX buffer and cycle/instruction
// counters. Load data is registered, one cycle after io_re.
// Build option: MMIO_RX_FIFO_EN selects an RX_FIFO_DEPTH-entry circular FIFO;
// without it the RX buffer is a single holding register.
module mmio_uart_bridge #(
  parameter int unsigned RX_FIFO_DEPTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input logic             clk,
  input logic             rst,
  mmio_uart_bridge_if.slave bus
);
  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_CYCLE  = 8'h10;
  localparam logic [7:0] ADDR_INSTR  = 8'h14;
  localparam logic [7:0] ADDR_CNTCLR = 8'h18;

  logic [7:0]            addr;
  logic                  tx_valid_q;
  logic [7:0]            tx_data_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] cyc_q, ins_q;
  logic                  rx_avail, rx_ready, rx_push, rx_pop;
  logic [7:0]            rx_head;
  logic                  tx_load, cnt_clr;
  logic                  unused_bits;

  assign addr        = bus.io_addr[7:0];
  assign unused_bits = ^{bus.io_addr[31:8], bus.io_wdata[DATA_WIDTH-1:8]};

  // Request decode: pops only from a non-empty buffer, TX loads only when free.
  always_comb begin
    tx_load = bus.io_we && (addr == ADDR_TXDATA) && !tx_valid_q;
    cnt_clr = bus.io_we && (addr == ADDR_CNTCLR);
    rx_pop  = bus.io_re && (addr == ADDR_RXDATA) && rx_avail;
    rx_push = bus.uart_rx_valid && rx_ready;
  end

`ifdef MMIO_RX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RX_FIFO_DEPTH);

  logic [7:0]       mem_q [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  assign rx_avail = (count_q != '0);
  assign rx_ready = (count_q != FULL_CNT);
  assign rx_head  = mem_q[rd_ptr_q];

  // FIFO storage; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && rx_push) mem_q[wr_ptr_q] <= bus.uart_rx_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (rx_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rx_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  localparam int unsigned rx_depth_unused = RX_FIFO_DEPTH;

  logic       rx_valid_q;
  logic [7:0] rx_hold_q;

  assign rx_avail = rx_valid_q;
  assign rx_ready = !rx_valid_q;
  assign rx_head  = rx_hold_q;

  // Single holding register; push and pop can never coincide since ready = !valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_hold_q  <= '0;
    end else if (rx_push) begin
      rx_valid_q <= 1'b1;
      rx_hold_q  <= bus.uart_rx_data;
    end else if (rx_pop) begin
      rx_valid_q <= 1'b0;
    end
  end
`endif

  // Load data mux from pre-update state; holds when no load is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.io_re) begin
      case (addr)
        ADDR_STATUS: rdata_d = {{(DATA_WIDTH-2){1'b0}}, rx_avail, !tx_valid_q};
        ADDR_RXDATA: rdata_d = rx_avail ? {{(DATA_WIDTH-8){1'b0}}, rx_head} : '0;
        ADDR_CYCLE:  rdata_d = cyc_q;
        ADDR_INSTR:  rdata_d = ins_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  // Registered load data.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  // TX holding register; a write while busy is dropped even on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (tx_valid_q && bus.uart_tx_ready) begin
      tx_valid_q <= 1'b0;
    end else if (tx_load) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= bus.io_wdata[7:0];
    end
  end

  // Free-running cycle and retire counters; a clear discards that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + DATA_WIDTH'(1);
      if (bus.inst_retire) ins_q <= ins_q + DATA_WIDTH'(1);
    end
  end

  assign bus.io_rdata      = rdata_q;
  assign bus.uart_tx_data  = tx_data_q;
  assign bus.uart_tx_valid = tx_valid_q;
  assign bus.uart_rx_ready = rx_ready;
endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: directed steps then random traffic,
// compared against a queue-based reference model of the register map.
module tb_mmio_uart_bridge;
  localparam int DEPTH = 8;
`ifdef MMIO_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  mmio_uart_bridge_if #(.DATA_WIDTH(32)) bus ();

  mmio_uart_bridge #(.RX_FIFO_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [7:0]  mq[$];
  logic        m_txv;
  logic [7:0]  m_txd;
  logic [31:0] m_cyc, m_ins, m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {30'b0, (mq.size() != 0), !m_txv};
      8'h04:   return (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0;
      8'h10:   return m_cyc;
      8'h14:   return m_ins;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rdata"},    bus.io_rdata, m_rd);
    check({tag, ".tx_valid"}, 32'(bus.uart_tx_valid), 32'(m_txv));
    check({tag, ".tx_data"},  32'(bus.uart_tx_data), 32'(m_txd));
    check({tag, ".rx_ready"}, 32'(bus.uart_rx_ready), 32'(mq.size() < CAP));
  endtask

  // One clock: evaluate model from pre-edge state and inputs, then compare.
  task automatic tick(input string tag);
    logic [7:0]  a;
    logic        push, pop, nt_v;
    logic [7:0]  nt_d, pdata;
    logic [31:0] nrd, ncyc, nins;
    a     = bus.io_addr[7:0];
    push  = bus.uart_rx_valid && (mq.size() < CAP);
    pop   = bus.io_re && (a == 8'h04) && (mq.size() != 0);
    pdata = bus.uart_rx_data;
    nrd   = bus.io_re ? m_read(a) : m_rd;
    nt_v  = m_txv;
    nt_d  = m_txd;
    if (m_txv && bus.uart_tx_ready) nt_v = 1'b0;
    else if (bus.io_we && a == 8'h08 && !m_txv) begin
      nt_v = 1'b1;
      nt_d = bus.io_wdata[7:0];
    end
    if (bus.io_we && a == 8'h18) begin
      ncyc = 0;
      nins = 0;
    end else begin
      ncyc = m_cyc + 1;
      nins = m_ins + 32'(bus.inst_retire);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_txv = 0; m_txd = 0; m_cyc = 0; m_ins = 0; m_rd = 0;
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(pdata);
      m_txv = nt_v; m_txd = nt_d; m_cyc = ncyc; m_ins = nins; m_rd = nrd;
    end
    check_all(tag);
  endtask

  task automatic set_io(input logic [31:0] addr, input logic [31:0] wd,
                        input logic we, input logic re);
    bus.io_addr  = addr;
    bus.io_wdata = wd;
    bus.io_we    = we;
    bus.io_re    = re;
  endtask

  initial begin
    logic [7:0] amap [8];
    amap = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'hFC};
    m_txv = 0; m_txd = 0; m_cyc = 0; m_ins = 0; m_rd = 0;
    rst = 1'b1;
    set_io(0, 0, 0, 0);
    bus.inst_retire   = 0;
    bus.uart_tx_ready = 0;
    bus.uart_rx_data  = 8'hEE;
    bus.uart_rx_valid = 1;   // pushes during reset must be ignored
    tick("rst0");
    tick("rst1");
    bus.uart_rx_valid = 0;
    rst = 1'b0;
    check("reset.rdata",    bus.io_rdata, 32'h0);
    check("reset.tx_valid", 32'(bus.uart_tx_valid), 32'h0);
    check("reset.tx_data",  32'(bus.uart_tx_data), 32'h0);
    check("reset.rx_ready", 32'(bus.uart_rx_ready), 32'h1);

    set_io(32'h0, 0, 0, 1);
    tick("rd_status");
    check("status_after_reset", bus.io_rdata, 32'h1);

    // TX: second write while busy is dropped
    set_io(32'h8, 32'h41, 1, 0); tick("tx_w41");
    set_io(32'h8, 32'h42, 1, 0); tick("tx_w42");
    set_io(0, 0, 0, 0);          tick("tx_hold");
    check("tx_held_valid", 32'(bus.uart_tx_valid), 32'h1);
    check("tx_held_data",  32'(bus.uart_tx_data), 32'h41);
    bus.uart_tx_ready = 1; tick("tx_hs");
    bus.uart_tx_ready = 0;
    check("tx_cleared", 32'(bus.uart_tx_valid), 32'h0);

    // RX: fill to capacity, extra byte blocked
    for (int k = 0; k < CAP; k++) begin
      bus.uart_rx_valid = 1;
      bus.uart_rx_data  = 8'(8'h10 + k);
      tick("rx_fill");
    end
    bus.uart_rx_data = 8'(8'h10 + CAP);
    tick("rx_extra_blocked");
    check("rx_full_ready", 32'(bus.uart_rx_ready), 32'h0);
    // pop on full with push asserted: no push this cycle
    set_io(32'h4, 0, 0, 1); tick("rx_pop_full");
    check("rx_pop_full_data", bus.io_rdata, 32'h10);
    check("rx_ready_after_pop", 32'(bus.uart_rx_ready), 32'h1);
    set_io(0, 0, 0, 0); tick("rx_extra_accept");
    bus.uart_rx_valid = 0;
    for (int k = 0; k < CAP; k++) begin
      set_io(32'h4, 0, 0, 1); tick("rx_drain");
      check("rx_order", bus.io_rdata, 32'(8'h11 + k));
    end
    tick("rx_empty_read");
    check("rx_empty_zero", bus.io_rdata, 32'h0);
    set_io(32'h0, 0, 0, 1); tick("rx_status");
    check("status_rx_empty", bus.io_rdata & 32'h2, 32'h0);

    // Counters
    set_io(32'h18, 0, 1, 0); tick("cnt_clr");
    set_io(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      bus.inst_retire = 1'(i % 2);
      tick("cnt_run");
    end
    bus.inst_retire = 0;
    set_io(32'h10, 0, 0, 1); tick("rd_cyc");
    check("cycle_cnt_100", bus.io_rdata, 32'd100);
    set_io(32'h14, 0, 0, 1); tick("rd_ins");
    check("instr_cnt_50", bus.io_rdata, 32'd50);
    bus.inst_retire = 1;
    set_io(32'h18, 0, 1, 0); tick("cnt_clr2");
    bus.inst_retire = 0;
    set_io(32'h10, 0, 0, 1); tick("rd_cyc2");
    check("cycle_after_clr", bus.io_rdata, 32'd0);
    set_io(32'h14, 0, 0, 1); tick("rd_ins2");
    check("instr_after_clr", bus.io_rdata, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_io({$urandom_range(0, 16777215), amap[$urandom_range(0, 7)]}, $urandom,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      bus.inst_retire   = 1'($urandom_range(0, 1));
      bus.uart_tx_ready = 1'($urandom_range(0, 2) == 0);
      bus.uart_rx_valid = 1'($urandom_range(0, 1));
      bus.uart_rx_data  = 8'($urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
